sram_axi_bridge: RTL and testbench
==================================

# sram_axi_bridge

Single-outstanding bridge that arbitrates the core's instruction-SRAM and data-SRAM request ports onto one AXI3/AXI4 master interface. It sits between the CPU core and the SoC AXI interconnect. It drives the core's external stall input so the whole pipeline freezes while any pending SRAM access is still on the bus. Data accesses take priority over instruction fetches.

## Interface
- `INST_ID`, default 4'd0: ARID for instruction reads.
- `DATA_ID`, default 4'd1: ARID/AWID for data accesses.
- `clk` in 1: core clock; all logic on rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `inst_sram_en` in 1: instruction fetch request.
- `inst_sram_addr` in 32: fetch byte address, word aligned.
- `inst_sram_rdata` out 32: fetched word, registered.
- `data_sram_en` in 1: data access request.
- `data_sram_wen` in 4: byte write strobes; 0 means read.
- `data_sram_addr` in 32: data byte address.
- `data_sram_wdata` in 32: store data, already lane-aligned.
- `data_sram_rdata` out 32: load word, registered.
- `stallreq` out 1: to the core's `stallreq_from_outside`; combinational.
- `arid`/`araddr`/`arvalid` out 4/32/1; `arready` in 1: read address channel. Fixed: arlen 0, arsize 3'd2, arburst 2'b01, arlock/arcache/arprot 0.
- `rid`/`rdata`/`rresp`/`rlast`/`rvalid` in 4/32/2/1/1; `rready` out 1.
- `awid`/`awaddr`/`awvalid` out 4/32/1; `awready` in 1. Fixed awlen/awsize/awburst as for AR.
- `wid`/`wdata`/`wstrb`/`wlast`/`wvalid` out 4/32/4/1/1; `wready` in 1. wlast=1.
- `bid`/`bresp`/`bvalid` in 4/2/1; `bready` out 1.

## Operation
- States: IDLE, D_AR, D_R, D_W, D_B, I_AR, I_R, DONE.
- Flags `data_done` and `inst_done` mark requests already serviced in the current core cycle. Pending-data = `data_sram_en & ~data_done`. Pending-inst = `inst_sram_en & ~inst_done`.
- IDLE dispatch:
  - pending-data with wen==0 -> D_AR.
  - pending-data with wen!=0 -> D_W.
  - otherwise pending-inst -> I_AR.
  - otherwise stay.
- Address latching: on leaving IDLE, latch addr, wdata, wen. AR/AW address = {addr[31:2],2'b00}. wstrb = latched wen.
- D_AR/I_AR: arvalid=1; move to D_R/I_R on arready.
- D_R/I_R: rready=1. On rvalid, capture rdata into the matching rdata register and set the matching done flag. rresp and rid are ignored.
- D_W:
  - awvalid and wvalid both raised on entry.
  - Each drops independently after its own handshake; AW and W may complete in either order or in the same cycle.
  - Move to D_B once both have handshaked.
- D_B: bready=1. On bvalid, set data_done; bresp is ignored.
- After any completion: if the other request is still pending, go directly to its first state (data before inst). Otherwise go to DONE.
- DONE: stallreq=0; clear both done flags; go to IDLE.
- stallreq = (pending-data | pending-inst) & (state != DONE).
- The core holds en/addr/wen/wdata stable while stallreq=1.
- Only one AXI transaction is outstanding at any time.
- Reset values: state IDLE, all valid/ready outputs 0, done flags 0, both rdata registers 0, stallreq 0 (en inputs are 0 during reset).
- Reset mid-transaction: abort with no completion and return to IDLE at the next edge. The interconnect is reset by the same resetn.

## Timing
- Instruction-only fetch, arready=1, rvalid one cycle later:
  - T0 IDLE (stall=1).
  - T1 I_AR.
  - T2 I_R, rvalid.
  - T3 DONE: stall=0, inst_sram_rdata valid.
  - Stall is high for 3 cycles.
- Load and fetch in the same cycle: data AR/R completes first, then I_AR/I_R, then DONE. Minimum stall is 5 cycles.
- Store: D_W takes 1 cycle if both readies are 1, then D_B. Minimum stall is 3 cycles.
- Both rdata registers hold their value until overwritten by a later completion.
- arvalid/awvalid/wvalid never deassert before their handshake. Payloads are stable while valid is asserted.

## Test plan
- Fetch, arready=1, rvalid at T2 with rdata=0x24080001 -> araddr=addr, arid=0. stallreq high T0–T2, low T3 with inst_sram_rdata=0x24080001.
- Simultaneous load 0x8000_1004 and fetch 0xBFC0_0010 -> first AR carries arid=1, araddr=0x80001004; second carries arid=0. Each rdata register gets its own beat. stallreq drops only in DONE.
- Store wen=4'b0011, addr 0x80000006, wdata 0x0000BEEF; awready=0 for 3 cycles, wready=1 -> W handshakes first and awvalid holds. awaddr=0x80000004, wstrb=0011. After bvalid, stall is released.
- arready delayed 5 cycles, rvalid delayed 4 more -> araddr stable throughout. stallreq continuous, no duplicate AR issued.
- resetn low during I_R -> at the next edge arvalid=rready=0, state IDLE, stallreq=0 with en low. A later clean fetch succeeds.
- No requests for 10 cycles -> all valids 0, stallreq 0, rdata registers unchanged.

Source files
------------

// File: rtl/sram_axi_bridge.sv
// Bridges the core's instruction- and data-SRAM request ports onto a single AXI master,
// one transaction at a time, data before instruction. stallreq freezes the core until both are served.
module sram_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] D_AR = 3'd1;
  localparam logic [2:0] D_R  = 3'd2;
  localparam logic [2:0] D_W  = 3'd3;
  localparam logic [2:0] D_B  = 3'd4;
  localparam logic [2:0] I_AR = 3'd5;
  localparam logic [2:0] I_R  = 3'd6;
  localparam logic [2:0] DONE = 3'd7;

  logic [2:0]  state, state_nxt;
  logic        data_done, inst_done;
  logic        data_done_nxt, inst_done_nxt;
  logic        aw_done, w_done;
  logic        dispatch, take_data, take_inst;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wen_q;
  logic        pend_data, pend_inst;

  assign pend_data = data_sram_en & ~data_done;
  assign pend_inst = inst_sram_en & ~inst_done;
  assign stallreq  = (pend_data | pend_inst) & (state != DONE);

  // Completions and IDLE share one dispatcher, so a finished data access chains
  // straight into a pending fetch without passing through IDLE.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers latches.
  always_comb begin
    state_nxt     = state;
    data_done_nxt = data_done;
    inst_done_nxt = inst_done;
    dispatch      = 1'b0;
    take_data     = 1'b0;
    take_inst     = 1'b0;
    case (state)
      IDLE: dispatch = 1'b1;
      D_AR: if (arready) state_nxt = D_R;
      D_R:  if (rvalid) begin data_done_nxt = 1'b1; dispatch = 1'b1; end
      D_W:  if ((aw_done | awready) & (w_done | wready)) state_nxt = D_B;
      D_B:  if (bvalid) begin data_done_nxt = 1'b1; dispatch = 1'b1; end
      I_AR: if (arready) state_nxt = I_R;
      I_R:  if (rvalid) begin inst_done_nxt = 1'b1; dispatch = 1'b1; end
      DONE: begin
        data_done_nxt = 1'b0;
        inst_done_nxt = 1'b0;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (dispatch) begin
      if (data_sram_en & ~data_done_nxt) begin
        take_data = 1'b1;
        state_nxt = (|data_sram_wen) ? D_W : D_AR;
      end else if (inst_sram_en & ~inst_done_nxt) begin
        take_inst = 1'b1;
        state_nxt = I_AR;
      end else if (state != IDLE) begin
        state_nxt = DONE;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the update order inside the block is irrelevant.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= IDLE;
      data_done       <= 1'b0;
      inst_done       <= 1'b0;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      addr_q          <= 32'd0;
      wdata_q         <= 32'd0;
      wen_q           <= 4'd0;
      inst_sram_rdata <= 32'd0;
      data_sram_rdata <= 32'd0;
    end else begin
      state     <= state_nxt;
      data_done <= data_done_nxt;
      inst_done <= inst_done_nxt;
      if (take_data) begin
        addr_q  <= data_sram_addr;
        wdata_q <= data_sram_wdata;
        wen_q   <= data_sram_wen;
      end else if (take_inst) begin
        addr_q  <= inst_sram_addr;
        wen_q   <= 4'd0;
      end
      // AW and W retire independently; the flags only live while in D_W.
      if (state == D_W) begin
        if (awvalid & awready) aw_done <= 1'b1;
        if (wvalid & wready)   w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (state == D_R && rvalid) data_sram_rdata <= rdata;
      if (state == I_R && rvalid) inst_sram_rdata <= rdata;
    end
  end

  assign arvalid = (state == D_AR) | (state == I_AR);
  assign arid    = (state == I_AR) ? INST_ID : DATA_ID;
  assign araddr  = {addr_q[31:2], 2'b00};
  assign arlen   = 8'd0;
  assign arsize  = 3'd2;
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign rready  = (state == D_R) | (state == I_R);

  assign awvalid = (state == D_W) & ~aw_done;
  assign awid    = DATA_ID;
  assign awaddr  = {addr_q[31:2], 2'b00};
  assign awlen   = 8'd0;
  assign awsize  = 3'd2;
  assign awburst = 2'b01;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wvalid  = (state == D_W) & ~w_done;
  assign wid     = DATA_ID;
  assign wdata   = wdata_q;
  assign wstrb   = wen_q;
  assign wlast   = 1'b1;
  assign bready  = (state == D_B);

  // Response IDs/status are deliberately ignored.
  logic unused_ok;
  assign unused_ok = ^{rid, rresp, rlast, bid, bresp, addr_q[1:0]};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Self-checking bench: a delay-configurable AXI slave logs every handshake, and a
// request-level model predicts transactions, stall length and returned words.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  sram_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata), .stallreq(stallreq),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave configuration (written by the test sequence only).
  int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [31:0] seed = 32'd0;

  // Slave observations (written by the slave only).
  logic [35:0] ar_log[$];
  logic [35:0] aw_log[$];
  logic [39:0] w_log[$];
  int          proto_err = 0;
  int          aw_hs_cyc = 0, w_hs_cyc = 0;

  // Model state: what each rdata register should currently hold.
  logic [31:0] exp_inst = 32'd0;
  logic [31:0] exp_data = 32'd0;

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // AXI slave: handshakes sampled at posedge, responses driven at negedge.
  initial begin : slave
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, cyc;
    bit r_pend, b_pend, aw_ok, w_ok;
    logic [3:0]  r_id_q;
    logic [31:0] r_addr_q;
    logic        p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    logic [35:0] p_ar, p_aw;
    logic [39:0] p_w;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; cyc = 0;
    r_pend = 0; b_pend = 0; aw_ok = 0; w_ok = 0; r_id_q = 0; r_addr_q = 0;
    p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
    p_ar = 0; p_aw = 0; p_w = 0;
    arready = 0; rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
    awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (resetn === 1'b1) begin
        if (p_arv && !p_arr && (arvalid !== 1'b1 || {arid, araddr} !== p_ar)) proto_err++;
        if (p_awv && !p_awr && (awvalid !== 1'b1 || {awid, awaddr} !== p_aw)) proto_err++;
        if (p_wv && !p_wr && (wvalid !== 1'b1 || {wid, wstrb, wdata} !== p_w)) proto_err++;
        if ((arvalid || awvalid || wvalid) && (r_pend || b_pend)) proto_err++;
        if (rvalid && rready) r_pend = 0;
        if (bvalid && bready) b_pend = 0;
        if (arvalid && arready) begin
          ar_log.push_back({arid, araddr});
          r_pend = 1; r_cnt = 0; r_id_q = arid; r_addr_q = araddr;
        end
        if (awvalid && awready) begin
          aw_log.push_back({awid, awaddr}); aw_ok = 1; aw_hs_cyc = cyc;
        end
        if (wvalid && wready) begin
          w_log.push_back({wid, wstrb, wdata}); w_ok = 1; w_hs_cyc = cyc;
          if (wlast !== 1'b1) proto_err++;
        end
        if (aw_ok && w_ok) begin b_pend = 1; b_cnt = 0; aw_ok = 0; w_ok = 0; end
        p_arv = arvalid; p_arr = arready; p_ar = {arid, araddr};
        p_awv = awvalid; p_awr = awready; p_aw = {awid, awaddr};
        p_wv = wvalid;   p_wr = wready;   p_w = {wid, wstrb, wdata};
      end else begin
        r_pend = 0; b_pend = 0; aw_ok = 0; w_ok = 0;
        p_arv = 0; p_awv = 0; p_wv = 0; p_arr = 0; p_awr = 0; p_wr = 0;
      end
      @(negedge clk);
      if (resetn !== 1'b1) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
      end else begin
        if (arvalid) begin arready = (ar_cnt >= ar_delay); ar_cnt++; end
        else begin arready = 0; ar_cnt = 0; end
        if (awvalid) begin awready = (aw_cnt >= aw_delay); aw_cnt++; end
        else begin awready = 0; aw_cnt = 0; end
        if (wvalid) begin wready = (w_cnt >= w_delay); w_cnt++; end
        else begin wready = 0; w_cnt = 0; end
        if (r_pend) begin
          if (!rvalid) begin
            if (r_cnt >= r_delay) begin
              rvalid = 1; rid = r_id_q; rdata = r_addr_q ^ seed; rresp = 2'b00; rlast = 1;
            end else r_cnt++;
          end
        end else rvalid = 0;
        if (b_pend) begin
          if (!bvalid) begin
            if (b_cnt >= b_delay) begin bvalid = 1; bid = 4'd1; bresp = 2'b00; end
            else b_cnt++;
          end
        end else bvalid = 0;
      end
    end
  end

  task automatic set_delays(input int ard, input int rd, input int awd, input int wd, input int bd);
    ar_delay = ard; r_delay = rd; aw_delay = awd; w_delay = wd; b_delay = bd;
  endtask

  // One core request: model predicts AXI traffic, stall length and rdata values.
  task automatic do_req(input string name, input bit d_en, input logic [3:0] d_wen,
                        input logic [31:0] d_addr, input logic [31:0] d_wdata,
                        input bit i_en, input logic [31:0] i_addr);
    logic [35:0] e_ar[$];
    logic [35:0] e_aw[$];
    logic [39:0] e_w[$];
    int ar0, aw0, w0, exp_stall, stall_cnt, guard;
    ar0 = ar_log.size(); aw0 = aw_log.size(); w0 = w_log.size();
    exp_stall = 1;
    if (d_en) begin
      if (d_wen == 4'd0) begin
        e_ar.push_back({4'd1, align(d_addr)});
        exp_stall += ar_delay + 1 + r_delay + 1;
        exp_data = align(d_addr) ^ seed;
      end else begin
        e_aw.push_back({4'd1, align(d_addr)});
        e_w.push_back({4'd1, d_wen, d_wdata});
        exp_stall += ((aw_delay > w_delay) ? aw_delay : w_delay) + 1 + b_delay + 1;
      end
    end
    if (i_en) begin
      e_ar.push_back({4'd0, align(i_addr)});
      exp_stall += ar_delay + 1 + r_delay + 1;
      exp_inst = align(i_addr) ^ seed;
    end
    @(negedge clk);
    data_sram_en = d_en; data_sram_wen = d_wen; data_sram_addr = d_addr; data_sram_wdata = d_wdata;
    inst_sram_en = i_en; inst_sram_addr = i_addr;
    #1;
    stall_cnt = 0; guard = 0;
    while (stallreq === 1'b1 && guard < 500) begin
      stall_cnt++; guard++;
      @(negedge clk); #1;
    end
    checks++;
    if (guard >= 500) begin
      errors++; $display("FAIL %s timeout: stallreq still %b after %0d cycles", name, stallreq, guard);
    end
    checks++;
    if (stall_cnt !== exp_stall) begin
      errors++; $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_cnt, exp_stall);
    end
    checks++;
    if (inst_sram_rdata !== exp_inst) begin
      errors++; $display("FAIL %s inst_rdata: got %h expected %h", name, inst_sram_rdata, exp_inst);
    end
    checks++;
    if (data_sram_rdata !== exp_data) begin
      errors++; $display("FAIL %s data_rdata: got %h expected %h", name, data_sram_rdata, exp_data);
    end
    checks++;
    if (ar_log.size() - ar0 !== e_ar.size() || aw_log.size() - aw0 !== e_aw.size() ||
        w_log.size() - w0 !== e_w.size()) begin
      errors++;
      $display("FAIL %s txn_count: got ar/aw/w %0d/%0d/%0d expected %0d/%0d/%0d", name,
               ar_log.size() - ar0, aw_log.size() - aw0, w_log.size() - w0,
               e_ar.size(), e_aw.size(), e_w.size());
    end else begin
      foreach (e_ar[k]) begin
        checks++;
        if (ar_log[ar0 + k] !== e_ar[k]) begin
          errors++; $display("FAIL %s ar[%0d] {id,addr}: got %h expected %h", name, k, ar_log[ar0 + k], e_ar[k]);
        end
      end
      foreach (e_aw[k]) begin
        checks++;
        if (aw_log[aw0 + k] !== e_aw[k]) begin
          errors++; $display("FAIL %s aw {id,addr}: got %h expected %h", name, aw_log[aw0 + k], e_aw[k]);
        end
        checks++;
        if (w_log[w0 + k] !== e_w[k]) begin
          errors++; $display("FAIL %s w {id,strb,data}: got %h expected %h", name, w_log[w0 + k], e_w[k]);
        end
      end
    end
    data_sram_en = 1'b0; inst_sram_en = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({arvalid, awvalid, wvalid, rready, bready, stallreq} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl {arv,awv,wv,rr,br,stall}: got %b expected 000000",
                         {arvalid, awvalid, wvalid, rready, bready, stallreq});
    end
    checks++;
    if ({inst_sram_rdata, data_sram_rdata} !== 64'd0) begin
      errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", inst_sram_rdata, data_sram_rdata);
    end
    checks++;
    if ({arlen, arsize, arburst, awlen, awsize, awburst} !== {8'd0, 3'd2, 2'b01, 8'd0, 3'd2, 2'b01}) begin
      errors++; $display("FAIL fixed_len_size_burst: got %h expected %h",
                         {arlen, arsize, arburst, awlen, awsize, awburst}, {8'd0, 3'd2, 2'b01, 8'd0, 3'd2, 2'b01});
    end
    checks++;
    if ({arlock, arcache, arprot, awlock, awcache, awprot, wlast} !== {18'd0, 1'b1}) begin
      errors++; $display("FAIL fixed_lock_cache_prot_wlast: got %h expected %h",
                         {arlock, arcache, arprot, awlock, awcache, awprot, wlast}, {18'd0, 1'b1});
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    set_delays(0, 0, 0, 0, 0);
    seed = 32'h24080001 ^ 32'hBFC00000;
    do_req("fetch", 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 32'hBFC00000);
    checks++;
    if (inst_sram_rdata !== 32'h24080001) begin
      errors++; $display("FAIL fetch_word: got %h expected 24080001", inst_sram_rdata);
    end
  endtask

  task automatic test_load_fetch();
    set_delays(0, 0, 0, 0, 0);
    seed = $urandom;
    do_req("load_fetch", 1'b1, 4'd0, 32'h80001004, 32'd0, 1'b1, 32'hBFC00010);
  endtask

  task automatic test_store();
    logic [31:0] held;
    held = data_sram_rdata;
    set_delays(0, 0, 3, 0, 0);
    do_req("store", 1'b1, 4'b0011, 32'h80000006, 32'h0000BEEF, 1'b0, 32'd0);
    checks++;
    if (!(w_hs_cyc < aw_hs_cyc)) begin
      errors++; $display("FAIL store_order: w handshake cycle %0d, aw cycle %0d, expected w first", w_hs_cyc, aw_hs_cyc);
    end
    checks++;
    if (data_sram_rdata !== held) begin
      errors++; $display("FAIL store_keeps_rdata: got %h expected %h", data_sram_rdata, held);
    end
  endtask

  task automatic test_slow_read();
    set_delays(5, 4, 0, 0, 0);
    seed = $urandom;
    do_req("slow_fetch", 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 32'h1FC0_0104);
    do_req("slow_load", 1'b1, 4'd0, 32'h0000_2223, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic test_reset_mid();
    int ar0;
    set_delays(0, 10, 0, 0, 0);
    ar0 = ar_log.size();
    @(negedge clk);
    inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC0_0200;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (rready !== 1'b1) begin
      errors++; $display("FAIL mid_in_read: rready got %b expected 1", rready);
    end
    resetn = 1'b0; inst_sram_en = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({arvalid, rready, stallreq} !== 3'b000) begin
      errors++; $display("FAIL mid_reset {arv,rr,stall}: got %b expected 000", {arvalid, rready, stallreq});
    end
    checks++;
    if ({inst_sram_rdata, data_sram_rdata} !== 64'd0) begin
      errors++; $display("FAIL mid_reset_rdata: got %h/%h expected 0/0", inst_sram_rdata, data_sram_rdata);
    end
    checks++;
    if (ar_log.size() - ar0 !== 1) begin
      errors++; $display("FAIL mid_ar_count: got %0d expected 1", ar_log.size() - ar0);
    end
    exp_inst = 32'd0; exp_data = 32'd0;
    resetn = 1'b1;
    set_delays(0, 0, 0, 0, 0);
    seed = $urandom;
    do_req("post_reset_fetch", 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 32'hBFC0_0200);
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({arvalid, awvalid, wvalid, rready, bready, stallreq} !== 6'b0) begin
        errors++; $display("FAIL idle_ctrl cycle %0d: got %b expected 000000", i,
                           {arvalid, awvalid, wvalid, rready, bready, stallreq});
      end
    end
    checks++;
    if (inst_sram_rdata !== exp_inst || data_sram_rdata !== exp_data) begin
      errors++; $display("FAIL idle_rdata_hold: got %h/%h expected %h/%h",
                         inst_sram_rdata, data_sram_rdata, exp_inst, exp_data);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      bit d_en, i_en;
      logic [3:0] wen;
      d_en = 1'($urandom_range(0, 1));
      i_en = d_en ? 1'($urandom_range(0, 1)) : 1'b1;
      wen  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      seed = $urandom;
      do_req($sformatf("random_%0d", n), d_en, wen, $urandom, $urandom, i_en, $urandom);
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (proto_err !== 0) begin
      errors++; $display("FAIL axi_protocol: got %0d violations expected 0", proto_err);
    end
  endtask

  initial begin
    resetn = 1'b0;
    inst_sram_en = 1'b0; inst_sram_addr = 32'd0;
    data_sram_en = 1'b0; data_sram_wen = 4'd0; data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
    test_reset();
    test_fetch();
    test_load_fetch();
    test_store();
    test_slow_read();
    test_reset_mid();
    test_idle();
    test_random();
    test_idle();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
